cla_subtractor_seq: RTL



---
 rtl/cla_subtractor_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cla_subtractor_seq.sv
`timescale 1ns/1ps
// cla_subtractor_seq
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin (mod 2^WIDTH).
// One 4-bit carry-lookahead slice of a + ~b + carry is evaluated per clock,
// least-significant slice first, with the slice carry held in a register
// between cycles. Valid/ready handshake on both the operand and result side.
// WIDTH must be a multiple of 4 and at least 8.
//
// Optional build macro CLA_SUB_ADDMODE_EN adds an 'op' input (0 = subtract,
// 1 = add); in add mode b is used uninverted, carry-in is bin, and bout
// reports the final carry-out.
module cla_subtractor_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef CLA_SUB_ADDMODE_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);
    localparam int MSB    = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // sub_q = 1 selects a + ~b + carry; 0 selects a + b + carry.
    logic             sub_q, sub_d;
    logic             sub_in;

`ifdef CLA_SUB_ADDMODE_EN
    assign sub_in = ~op;
`else
    assign sub_in = 1'b1;
`endif

    // 4-bit carry-lookahead slice: returns {c4, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                        input logic c0);
        logic c1, c2, c3, c4;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

    logic [3:0] a_s, b_s, g_s, p_s;
    logic [4:0] slice_res;

    // Current slice operands and lookahead result for slice idx_q.
    always_comb begin
        a_s       = a_q[{idx_q, 2'b00} +: 4];
        b_s       = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};
        g_s       = a_s & b_s;
        p_s       = a_s ^ b_s;
        slice_res = cla4(g_s, p_s, carry_q);
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        sub_d   = sub_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub_in;
                    carry_d = sub_in ? ~bin : bin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[{idx_q, 2'b00} +: 4] = slice_res[3:0];
                carry_d = slice_res[4];
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                    // Subtract reports borrow (inverted carry); add reports carry.
                    bout_d  = sub_q ? ~slice_res[4] : slice_res[4];
                    zero_d  = (diff_d == '0);
                    // Overflow needs operand signs that differ (sub) or match (add),
                    // and a result sign that differs from a.
                    ovf_d   = ((a_q[MSB] ^ b_q[MSB]) == sub_q) && (diff_d[MSB] != a_q[MSB]);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            sub_q   <= sub_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
